// File: rtl/fetch_unit.sv
// Instruction fetch stage: fills a one-line buffer over the system bus
// and streams 32-bit instructions with their PC to the decoder.
module fetch_unit #(
  parameter int LINE_BEATS = 8,
  parameter int TAG_W      = 13
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [63:0]      entry,
  output logic             bus_reqcyc,
  output logic [63:0]      bus_req,
  output logic [TAG_W-1:0] bus_reqtag,
  input  logic             bus_reqack,
  input  logic             bus_respcyc,
  input  logic [63:0]      bus_resp,
  output logic             bus_respack,
  output logic [31:0]      instruction,
  output logic [63:0]      pc,
  output logic             instr_valid,
  input  logic             instr_ready,
  input  logic             redirect,
  input  logic [63:0]      redirect_pc,
  output logic             halt
);

  localparam int SLOTS = 2 * LINE_BEATS;
  localparam int SW    = $clog2(SLOTS);
  localparam int OW    = SW + 2;
  localparam int CW    = $clog2(LINE_BEATS);

  // read request into the memory space
  localparam logic [12:0] TAG_RD_MEM = {1'b1, 4'b0001, 8'h00};

  localparam logic [63:0] LINE_MASK = ~((64'd1 << OW) - 64'd1);
  localparam logic [CW-1:0] LAST_BEAT = CW'(LINE_BEATS - 1);
  localparam logic [SW-1:0] LAST_SLOT = SW'(SLOTS - 1);

  typedef enum logic [2:0] {
    S_BOOT,
    S_REQ,
    S_RESP,
    S_ISSUE,
    S_HALT
  } state_e;

  state_e        state_q, state_d;
  logic [63:0]   pc_q, pc_d;
  logic [63:0]   req_q, req_d;
  logic          stale_q, stale_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [31:0]   line_q [SLOTS];

  logic [SW-1:0] slot;
  logic [31:0]   cur;
  logic          cur_nz;
  logic [63:0]   rdr_pc;
  logic [SW-1:0] wr_lo;
  logic [SW-1:0] wr_hi;

  assign slot   = pc_q[OW-1:2];
  assign cur    = line_q[slot];
  assign cur_nz = |cur;
  assign rdr_pc = redirect_pc & ~64'h3;
  assign wr_lo  = {cnt_q, 1'b0};
  assign wr_hi  = {cnt_q, 1'b1};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_BOOT;
      pc_q    <= '0;
      req_q   <= '0;
      stale_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      req_q   <= req_d;
      stale_q <= stale_d;
      cnt_q   <= cnt_d;
    end
  end

  // line storage needs no reset: it is always filled before it is read
  always_ff @(posedge clk) begin
    if (bus_respack) begin
      line_q[wr_lo] <= bus_resp[31:0];
      line_q[wr_hi] <= bus_resp[63:32];
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    req_d   = req_q;
    stale_d = stale_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_BOOT: begin
        pc_d    = redirect ? rdr_pc : (entry & ~64'h3);
        state_d = S_REQ;
      end
      S_REQ: begin
        if (redirect) begin
          pc_d    = rdr_pc;
          stale_d = 1'b1;
        end
        if (bus_reqack) begin
          state_d = S_RESP;
          cnt_d   = '0;
        end
      end
      S_RESP: begin
        if (redirect) begin
          pc_d    = rdr_pc;
          stale_d = 1'b1;
        end
        if (bus_respcyc) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_BEAT) begin
            if (stale_q || redirect) begin
              state_d = S_REQ;
              stale_d = 1'b0;
            end else begin
              state_d = S_ISSUE;
            end
          end
        end
      end
      S_ISSUE: begin
        unique case (1'b1)
          redirect: begin
            pc_d    = rdr_pc;
            state_d = S_REQ;
          end
          !cur_nz: begin
            state_d = S_HALT;
          end
          default: begin
            if (instr_ready) begin
              pc_d = pc_q + 64'd4;
              if (slot == LAST_SLOT) state_d = S_REQ;
            end
          end
        endcase
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_BOOT;
      end
    endcase
    // capture the request address once so it holds until acked
    if (state_d == S_REQ && state_q != S_REQ) req_d = pc_d & LINE_MASK;
  end

  assign bus_reqcyc  = (state_q == S_REQ);
  assign bus_req     = bus_reqcyc ? req_q : '0;
  assign bus_reqtag  = bus_reqcyc ? TAG_W'(TAG_RD_MEM) : '0;
  assign bus_respack = (state_q == S_RESP) & bus_respcyc;
  assign instr_valid = (state_q == S_ISSUE) & cur_nz;
  assign instruction = instr_valid ? cur : '0;
  assign pc          = instr_valid ? pc_q : '0;
  assign halt        = (state_q == S_HALT);

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage directly upstream of the decoder. It fetches 64-byte cache lines from memory over the system bus (Sysbus.defs protocol), buffers one line, and delivers one 32-bit instruction per cycle with its PC under a valid/ready handshake. The decoder consumes `instruction`. Branch/jump resolution downstream steers fetch through a redirect port.

## Interface
- `LINE_BEATS`, 8: 64-bit bus beats per line (16 instructions).
- `TAG_W`, 13: bus tag width.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `entry`  in  64  program start PC, sampled in BOOT.
- `bus_reqcyc`  out  1  bus request valid.
- `bus_req`  out  64  request address (line-aligned).
- `bus_reqtag`  out  TAG_W  request tag: memory read, per Sysbus.defs.
- `bus_reqack`  in  1  request accepted.
- `bus_respcyc`  in  1  response beat valid.
- `bus_resp`  in  64  response beat data.
- `bus_respack`  out  1  response beat accepted.
- `instruction`  out  32  instruction to decoder.
- `pc`  out  64  address of `instruction`.
- `instr_valid`  out  1  `instruction`/`pc` valid.
- `instr_ready`  in  1  decoder accepts this cycle.
- `redirect`  in  1  discard stream, restart at `redirect_pc`.
- `redirect_pc`  in  64  new PC; bits [1:0] forced to 0.
- `halt`  out  1  all-zero instruction reached; fetch stopped.

## Operation
- States: BOOT, REQ, RESP, ISSUE, HALT.
- BOOT: first cycle after reset release. `pc_r <= {entry[63:2],2'b00}`, then go to REQ.
- REQ: `bus_reqcyc=1`, `bus_req={pc_r[63:6],6'b0}`, read/memory tag. Request is held stable until `bus_reqack`, then go to RESP with beat counter = 0.
- RESP: `bus_respack = bus_respcyc` (combinational). Each accepted beat k is written to line buffer slots 2k (bits [31:0]) and 2k+1 (bits [63:32]). The counter increments per beat; the 8th beat (counter wraps 7->0) exits to ISSUE, or to REQ if the `stale` flag is set (flag then clears).
- ISSUE: slot = `pc_r[5:2]`. `instr_valid=1`, `instruction=buf[slot]`, `pc=pc_r`. On transfer (`instr_valid && instr_ready`), `pc_r += 4`; after transferring slot 15, go to REQ for the next line.
- Zero instruction: if `buf[slot]==0` in ISSUE, it is not presented (`instr_valid=0`). Go to HALT.
- HALT: `halt=1`, no bus activity. Only `reset` exits; `redirect` is ignored.
- Redirect (priority over the handshake): `pc_r <= redirect_pc` aligned.
  - In ISSUE: no transfer that cycle; go to REQ.
  - In REQ before ack: request stays stable; `stale<=1`.
  - In RESP: remaining beats are still acked and written but discarded; `stale<=1`.
  - In BOOT: overrides `entry`.
- Bus `bus_resptag` is not checked; one outstanding request maximum.

## Timing
- Reset values (asynchronous): state BOOT, `pc_r=0`, `stale=0`, counter 0. All outputs are 0: `bus_reqcyc`, `bus_req`, `bus_reqtag`, `bus_respack`, `instruction`, `pc`, `instr_valid`, `halt`.
- Outputs other than `bus_respack` are registered/state-decoded, with no combinational path from `instr_ready` to any output.
- With same-cycle `bus_reqack` and back-to-back beats: REQ (1 cycle) then RESP (8 cycles), and `instr_valid` is high on the next cycle. First instruction arrives 10 cycles after BOOT.
- Redirect in ISSUE: REQ for the new line starts the next cycle.
- Throughput: 1 instruction/cycle within a line while `instr_ready=1`.
- Backpressure: while `instr_valid && !instr_ready`, `instruction` and `pc` stay stable.
- Reset mid-burst: outputs drop immediately; the bus sees `bus_respack=0` for the remaining beats.

## Test plan
- entry=0x1000, ack in 1 cycle, beat k = {32'h00100093+2k+1, 32'h00100093+2k}: expect req 0x1000, then 16 transfers with pc 0x1000..0x103C in slot order, then REQ 0x1040.
- entry=0x1038: expect req 0x1000, then only pc 0x1038 and 0x103C issued, then REQ 0x1040.
- `instr_ready` low 5 cycles at pc 0x1008: expect `instruction`/`pc` constant and no pc advance; the pc 0x100C transfer occurs the cycle after ready returns.
- redirect to 0x2006 during RESP beat 3: expect beats 4-7 acked, next req 0x2000, first issued pc 0x2004.
- line with slot 2 = 32'h0 from entry 0x1000: expect pc 0x1000 and 0x1004 issued, then `halt=1`, `instr_valid=0`, no further `bus_reqcyc`.
- assert `reset` during RESP beat 5: expect all outputs 0 immediately; after release, BOOT then req for the entry line again.
